// File: rtl/pool_ctrl.sv
// Max-pool sequencer: pads each row with most-negative columns, feeds the pooling core,
// tracks results through the core pipeline and queues them in a credit-protected output FIFO.
module pool_ctrl #(
   parameter int FEATURE_WIDTH = 16,
   parameter int MAXPOOL_SIZE  = 5,
   parameter int DIM_WIDTH     = 10,
   parameter int CORE_LAT      = 4,
   parameter int OFIFO_DEPTH   = 8
) (
   input  logic                                    DSP_clk,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic [DIM_WIDTH-1:0]                    img_width,
   input  logic [DIM_WIDTH-1:0]                    img_height,
   input  logic [FEATURE_WIDTH*MAXPOOL_SIZE-1:0]   col_data,
   input  logic                                    col_valid,
   output logic                                    col_ready,
   output logic [FEATURE_WIDTH*MAXPOOL_SIZE-1:0]   core_feature,
   output logic                                    core_pulse,
   input  logic [FEATURE_WIDTH-1:0]                core_feature_out,
   output logic [FEATURE_WIDTH-1:0]                out_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    out_last,
   output logic                                    busy,
   output logic                                    done
);

   localparam int PAD = MAXPOOL_SIZE / 2;
   localparam int PW  = DIM_WIDTH + 2;
   localparam int AW  = $clog2(OFIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int IW  = $clog2(CORE_LAT + 1);
   localparam logic [FEATURE_WIDTH-1:0] MOST_NEG = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};
   localparam logic [FEATURE_WIDTH*MAXPOOL_SIZE-1:0] PAD_COL = {MAXPOOL_SIZE{MOST_NEG}};

   typedef enum logic [2:0] {IDLE, LPAD, BODY, RPAD, ROW_END, DRAIN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [DIM_WIDTH-1:0]   width_q, width_d;
   logic [DIM_WIDTH-1:0]   height_q, height_d;
   logic [DIM_WIDTH-1:0]   row_q, row_d;
   logic [PW-1:0]          p_q, p_d;
   logic [CORE_LAT-1:0]    tag_vld_q, tag_last_q;
   logic [FEATURE_WIDTH-1:0] fifo_dat_q [OFIFO_DEPTH];
   logic [OFIFO_DEPTH-1:0] fifo_last_q;
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          count_q;

   logic [IW-1:0]          inflight;
   logic [31:0]            occupancy;
   logic                   has_credit;
   logic                   push, launch, launch_last;
   logic                   fifo_push, fifo_pop;
   logic [PW-1:0]          lpad_last_p, body_last_p, row_last_p;
   logic                   last_row;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < CORE_LAT; i++) inflight = inflight + IW'(tag_vld_q[i]);
   end

   // Results already launched into the core reserve their FIFO slot up front.
   assign occupancy   = 32'(count_q) + 32'(inflight);
   assign has_credit  = occupancy < 32'(OFIFO_DEPTH);

   assign lpad_last_p = PW'(PAD - 1);
   assign body_last_p = PW'(width_q) + PW'(PAD - 1);
   assign row_last_p  = PW'(width_q) + PW'(2 * PAD - 1);
   assign last_row    = (row_q == height_q - DIM_WIDTH'(1));

   always_comb begin
      state_d      = state_q;
      width_d      = width_q;
      height_d     = height_q;
      row_d        = row_q;
      p_d          = p_q;
      push         = 1'b0;
      col_ready    = 1'b0;
      core_feature = '0;
      done         = 1'b0;
      busy         = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               width_d  = img_width;
               height_d = img_height;
               row_d    = '0;
               p_d      = '0;
               state_d  = LPAD;
            end
         end
         LPAD: begin
            core_feature = PAD_COL;
            push         = has_credit;
            if (push) begin
               p_d = p_q + PW'(1);
               if (p_q == lpad_last_p) state_d = BODY;
            end
         end
         BODY: begin
            core_feature = col_data;
            col_ready    = has_credit;
            push         = col_valid && has_credit;
            if (push) begin
               p_d = p_q + PW'(1);
               if (p_q == body_last_p) state_d = RPAD;
            end
         end
         RPAD: begin
            core_feature = PAD_COL;
            push         = has_credit;
            if (push) begin
               p_d = p_q + PW'(1);
               if (p_q == row_last_p) state_d = ROW_END;
            end
         end
         ROW_END: begin
            row_d   = row_q + DIM_WIDTH'(1);
            p_d     = '0;
            state_d = last_row ? DRAIN : LPAD;
         end
         DRAIN: begin
            if (inflight == '0 && count_q == '0) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign core_pulse  = push;
   // The first MAXPOOL_SIZE-1 pushes of a row only prime the window.
   assign launch      = push && (p_q >= PW'(MAXPOOL_SIZE - 1));
   assign launch_last = launch && last_row && (p_q == row_last_p);

   assign fifo_push = tag_vld_q[CORE_LAT-1];
   assign out_valid = (count_q != '0);
   assign fifo_pop  = out_valid && out_ready;
   assign out_data  = out_valid ? fifo_dat_q[rd_ptr_q] : '0;
   assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

   always_ff @(posedge DSP_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         width_q    <= '0;
         height_q   <= '0;
         row_q      <= '0;
         p_q        <= '0;
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         width_q    <= width_d;
         height_q   <= height_d;
         row_q      <= row_d;
         p_q        <= p_d;
         tag_vld_q  <= CORE_LAT'({tag_vld_q, launch});
         tag_last_q <= CORE_LAT'({tag_last_q, launch_last});
         if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({fifo_push, fifo_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge DSP_clk) begin
      if (fifo_push) begin
         fifo_dat_q[wr_ptr_q]  <= core_feature_out;
         fifo_last_q[wr_ptr_q] <= tag_last_q[CORE_LAT-1];
      end
   end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter FEATURE_WIDTH, default 16, bits per feature element.
REQ-002 Parameter MAXPOOL_SIZE, default 5, window edge; padding PAD = MAXPOOL_SIZE/2 = 2 columns per side.
REQ-003 Parameter DIM_WIDTH, default 10, width of image dimension and counters.
REQ-004 Parameter CORE_LAT, default 4, cycles from a core_pulse cycle to the matching valid core_feature_out.
REQ-005 Parameter OFIFO_DEPTH, default 8, output FIFO entries (power of two).
REQ-006 DSP_clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  one-cycle request to begin a map; ignored unless in IDLE.
REQ-009 img_width  input  DIM_WIDTH  columns per row; sampled on accepted start; legal range 1..2^DIM_WIDTH-1.
REQ-010 img_height  input  DIM_WIDTH  rows per map; sampled on accepted start; legal range 1..2^DIM_WIDTH-1.
REQ-011 col_data  input  FEATURE_WIDTH*MAXPOOL_SIZE  one input column (MAXPOOL_SIZE vertically adjacent pixels, lane i at bits [FEATURE_WIDTH*i +: FEATURE_WIDTH]).
REQ-012 col_valid / col_ready  input / output  1 each  column handshake; transfer when both high.
REQ-013 core_feature  output  FEATURE_WIDTH*MAXPOOL_SIZE  column driven to pooling core.
REQ-014 core_pulse  output  1  core advance strobe, high exactly in cycles a column is pushed.
REQ-015 core_feature_out  input  FEATURE_WIDTH  signed window max from core.
REQ-016 out_data / out_valid / out_ready  output / output / input  FEATURE_WIDTH / 1 / 1  pooled result stream from FIFO head.
REQ-017 out_last  output  1  high with out_valid on the final pixel of the map.
REQ-018 busy / done  output / output  1 each  busy high outside IDLE; done one-cycle pulse at completion.

Function
REQ-019 FSM states SHALL be IDLE, LPAD, BODY, RPAD, ROW_END, DRAIN, DONE.
REQ-020 IDLE->LPAD on start; LPAD pushes PAD pad columns then ->BODY; BODY pushes img_width source columns then ->RPAD; RPAD pushes PAD pad columns then ->ROW_END.
REQ-021 ROW_END (1 cycle) increments row counter; ->LPAD if rows remain, else ->DRAIN.
REQ-022 DRAIN ->DONE when no result in flight and FIFO empty; DONE asserts done for 1 cycle ->IDLE.
REQ-023 Pad column: every lane = most-negative value (0x8000 for 16 bits); core_feature = col_data in BODY.
REQ-024 Credit = OFIFO_DEPTH - fifo_count - inflight; push allowed only if credit > 0.
REQ-025 col_ready = (state==BODY) && credit>0; core_pulse = pad push in LPAD/RPAD, or col_valid&&col_ready in BODY.
REQ-026 Padded column index p counts 0..img_width+3 per row; a push with p >= MAXPOOL_SIZE-1 SHALL launch a result tag.
REQ-027 Tags travel a free-running CORE_LAT-stage shift register (not gated by core_pulse); on exit core_feature_out is written to FIFO; inflight counts tags in the shift register.
REQ-028 Exactly img_width results per row, img_width*img_height per map, in raster order.
REQ-029 Tag carries a last flag set for the final result of the last row; propagates to out_last.
REQ-030 FIFO pop on out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged; FIFO never overflows by construction (REQ-024).
REQ-031 Stall on credit or col_valid low holds core_pulse low; no column lost or duplicated.
REQ-032 start while busy SHALL be ignored with no effect on the running map.

Reset
REQ-033 On rst_n low, immediately: state IDLE, counters, tags, FIFO cleared; col_ready, core_pulse, out_valid, out_last, busy, done = 0; core_feature = 0; out_data = 0.
REQ-034 Reset mid-map SHALL discard all in-flight and queued results; next map begins only on a new start.

Verification
REQ-035 width 6, height 1, ramp 1..6 all lanes, out_ready=1 -> outputs 3,4,5,6,6,6; out_last on 6th; done one cycle after FIFO empties.
REQ-036 width 1, height 2, all values -5 -> two outputs -5 (pad never wins), out_last on second.
REQ-037 width 16, height 3, out_ready=0 -> exactly 8 results queued, core_pulse stops, col_ready low; release -> 48 outputs in raster order, none lost.
REQ-038 col_valid toggling 50% random, width 10, height 4 -> results identical to gap-free run.
REQ-039 start asserted mid-map -> ignored; output count unchanged.
REQ-040 rst_n pulsed mid-row 2 -> all outputs 0 immediately; fresh start produces full correct map.
